// File: rtl/alu_pkg.sv
// Shared op codes, ALUOp/funct7 encodings and FSM state encoding
// for the alu_ctrl_seq execute-stage ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } op_t;

  localparam logic [1:0] ALUOP_LS  = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // funct3 map shared by R-type (funct7 0) and I-type
  function automatic op_t base_map(input logic [2:0] f3);
    op_t o;
    unique case (f3)
      3'b000: o = OP_ADD;
      3'b001: o = OP_SLL;
      3'b010: o = OP_SLT;
      3'b011: o = OP_SLTU;
      3'b100: o = OP_XOR;
      3'b101: o = OP_SRL;
      3'b110: o = OP_OR;
      3'b111: o = OP_AND;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_mdu_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply
// and restoring divide on unsigned magnitudes.
// Ports: clk, reset, start (load a/b/div), div (mode), a, b
// (magnitudes), en (one step), acc_next (post-step acc), last.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              en,
  output logic [2*XLEN-1:0] acc_next,
  output logic              last
);

  localparam int CW = $clog2(XLEN);

  // mul: {partial high, multiplier shifting out}
  // div: {remainder, dividend shifting out / quotient in}
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mag_b;
  logic [CW-1:0]     cnt;
  logic              div_q;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;

  assign last = (cnt == '0);

  always_comb begin
    addend = acc[0] ? mag_b : '0;
    sum    = {1'b0, acc[2*XLEN-1:XLEN]}
           + {1'b0, addend};
    trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]}
           - {1'b0, mag_b};
    acc_next = {sum, acc[XLEN-1:1]};
    if (div_q) begin
      // trial MSB set means the subtract borrowed
      if (!trial[XLEN])
        acc_next = {trial[XLEN-1:0],
                    acc[XLEN-2:0], 1'b1};
      else
        acc_next = {acc[2*XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      mag_b <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc   <= {{XLEN{1'b0}}, a};
      mag_b <= b;
      cnt   <= CW'(XLEN-1);
      div_q <= div;
    end else if (en) begin
      acc <= acc_next;
      if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Execute-stage ALU: control decode, base ALU, M-extension fast
// paths and an iterative mul/div sequencer behind valid/ready.
// Ports: clk, reset, in_valid/in_ready, ALUOp, funct7, funct3,
// operand_a, operand_b, out_valid, result, zero, illegal.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state;
  op_t    op_dec;
  op_t    op_q;
  logic   ill_dec;
  logic   accept;
  logic   neg_q;
  logic   neg_r;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] spec_y;
  logic [XLEN-1:0] fast_y;
  logic [XLEN-1:0] fix_y;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            mul_op;
  logic            div_op;
  logic            sgn_a;
  logic            sgn_b;
  logic            neg_a;
  logic            neg_b;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic            fast;
  logic            mdu_en;
  logic            last;

  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = operand_b[SW-1:0];

  always_comb begin
    op_dec  = OP_ADD;
    ill_dec = 1'b0;
    unique case (ALUOp)
      ALUOP_LS: op_dec = OP_ADD;
      ALUOP_BR: op_dec = OP_SUB;
      ALUOP_R: begin
        if (funct7 == F7_BASE)
          op_dec = base_map(funct3);
        else if (funct7 == F7_ALT
                 && funct3 == 3'b000)
          op_dec = OP_SUB;
        else if (funct7 == F7_ALT
                 && funct3 == 3'b101)
          op_dec = OP_SRA;
        else if (ENABLE_M && funct7 == F7_M)
          op_dec = op_t'(5'd10 + {2'b00, funct3});
        else
          ill_dec = 1'b1;
      end
      ALUOP_I: begin
        op_dec = base_map(funct3);
        if (funct3 == 3'b101 && funct7 == F7_ALT)
          op_dec = OP_SRA;
      end
    endcase
  end

  always_comb begin
    unique case (op_dec)
      OP_ADD:  alu_y = operand_a + operand_b;
      OP_SUB:  alu_y = operand_a - operand_b;
      OP_AND:  alu_y = operand_a & operand_b;
      OP_OR:   alu_y = operand_a | operand_b;
      OP_XOR:  alu_y = operand_a ^ operand_b;
      OP_SLL:  alu_y = operand_a << shamt;
      OP_SRL:  alu_y = operand_a >> shamt;
      OP_SRA:  alu_y = $signed(operand_a) >>> shamt;
      OP_SLT:  alu_y = {{(XLEN-1){1'b0}},
                 $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_y = {{(XLEN-1){1'b0}},
                 operand_a < operand_b};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    mul_op = op_dec inside {[OP_MUL:OP_MULHU]};
    div_op = op_dec inside {[OP_DIV:OP_REMU]};
    sgn_a  = op_dec inside {OP_MUL, OP_MULH,
                            OP_MULHSU, OP_DIV, OP_REM};
    sgn_b  = op_dec inside {OP_MUL, OP_MULH,
                            OP_DIV, OP_REM};
    neg_a  = sgn_a && operand_a[XLEN-1];
    neg_b  = sgn_b && operand_b[XLEN-1];
    mag_a  = neg_a ? -operand_a : operand_a;
    mag_b  = neg_b ? -operand_b : operand_b;
    b_zero = (operand_b == '0);
    ovf    = (op_dec inside {OP_DIV, OP_REM})
          && operand_a == MIN_NEG
          && (&operand_b);
    special = div_op && (b_zero || ovf);
    spec_y  = '0;
    if (b_zero)
      spec_y = (op_dec inside {OP_DIV, OP_DIVU})
             ? '1 : operand_a;
    else if (ovf && op_dec == OP_DIV)
      spec_y = operand_a;
    fast   = ill_dec || !(mul_op || div_op) || special;
    fast_y = ill_dec ? '0 : (special ? spec_y : alu_y);
  end

  // Sign fix-up on the final (post-step) accumulator
  always_comb begin
    prod = neg_q ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:  fix_y = prod[XLEN-1:0];
      OP_DIV,
      OP_DIVU: fix_y = neg_q ? -quo : quo;
      OP_REM,
      OP_REMU: fix_y = neg_r ? -rem : rem;
      default: fix_y = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign mdu_en = (state == ST_MUL)
               || (state == ST_DIV);

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && !fast),
    .div      (div_op),
    .a        (mag_a),
    .b        (mag_b),
    .en       (mdu_en),
    .acc_next (acc_next),
    .last     (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept && fast) begin
            result    <= fast_y;
            zero      <= (fast_y == '0);
            illegal   <= ill_dec;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (accept) begin
            op_q  <= op_dec;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            state <= mul_op ? ST_MUL : ST_DIV;
          end
        end
        ST_MUL,
        ST_DIV: begin
          if (last) begin
            result    <= fix_y;
            zero      <= (fix_y == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          out_valid <= 1'b0;
          illegal   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed vector table,
// random ops against a reference model, and a mid-op reset.
module tb_alu_ctrl_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int nerr = 0;
  int nchk = 0;

  alu_ctrl_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .funct7    (funct7),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ill;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vq[$];

  string base_nm[8] = '{"add", "sll", "slt", "sltu",
                        "xor", "srl", "or", "and"};
  string m_nm[8] = '{"mul", "mulh", "mulhsu", "mulhu",
                     "div", "divu", "rem", "remu"};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference: decode to an instruction name, then evaluate it
  // with 64-bit integer arithmetic.
  function automatic void model(
    input  logic [1:0]  op,
    input  logic [6:0]  f7,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        ill,
    output int          lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint p;
    longint unsigned pu;
    bit ovf;
    string m;
    ill = 1'b0;
    lat = 1;
    r   = '0;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    if (op == 2'd0) m = "add";
    else if (op == 2'd1) m = "sub";
    else if (op == 2'd3)
      m = (f3 == 3'd5 && f7 == 7'h20) ? "sra"
                                      : base_nm[f3];
    else if (f7 == 7'h00) m = base_nm[f3];
    else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
    else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
    else if (f7 == 7'h01) m = m_nm[f3];
    else m = "ill";
    if (m == "add") r = a + b;
    else if (m == "sub") r = a - b;
    else if (m == "and") r = a & b;
    else if (m == "or") r = a | b;
    else if (m == "xor") r = a ^ b;
    else if (m == "sll") r = a << b[4:0];
    else if (m == "srl") r = a >> b[4:0];
    else if (m == "sra") r = $signed(a) >>> b[4:0];
    else if (m == "slt") r = (sa < sb) ? 1 : 0;
    else if (m == "sltu") r = (ua < ub) ? 1 : 0;
    else if (m == "mul") begin
      p = sa * sb; r = p[31:0]; lat = 33;
    end else if (m == "mulh") begin
      p = sa * sb; r = p[63:32]; lat = 33;
    end else if (m == "mulhsu") begin
      p = sa * longint'(ub); r = p[63:32]; lat = 33;
    end else if (m == "mulhu") begin
      pu = ua * ub; r = pu[63:32]; lat = 33;
    end else if (m == "div") begin
      if (b == 0) r = '1;
      else if (ovf) r = a;
      else begin p = sa / sb; r = p[31:0]; lat = 33; end
    end else if (m == "divu") begin
      if (b == 0) r = '1;
      else begin pu = ua / ub; r = pu[31:0]; lat = 33; end
    end else if (m == "rem") begin
      if (b == 0) r = a;
      else if (ovf) r = '0;
      else begin p = sa % sb; r = p[31:0]; lat = 33; end
    end else if (m == "remu") begin
      if (b == 0) r = a;
      else begin pu = ua % ub; r = pu[31:0]; lat = 33; end
    end else ill = 1'b1;
  endfunction

  task automatic run_op(input logic [1:0]  op,
                        input logic [6:0]  f7,
                        input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic        eill,
                        input int          elat,
                        input string       nm);
    int lat = 0;
    int busy_bad = 0;
    logic got = 1'b0;
    @(negedge clk);
    ALUOp = op; funct7 = f7; funct3 = f3;
    operand_a = a; operand_b = b;
    in_valid = 1'b1;
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    repeat (40) begin
      @(negedge clk);
      if (lat == 0) begin
        in_valid  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        funct3    = 3'($urandom);
      end
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      if (in_ready) busy_bad++;
    end
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_busy"}, 32'(busy_bad), 32'd0);
    chk({nm, "_res"}, result, er);
    chk({nm, "_ill"}, 32'(illegal), 32'(eill));
    chk({nm, "_zero"}, 32'(zero), 32'(er == 0));
    @(negedge clk);
    chk({nm, "_ovlo"}, 32'(out_valid), 32'd0);
    chk({nm, "_rdyhi"}, 32'(in_ready), 32'd1);
    chk({nm, "_hold"}, result, er);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [6:0]  rf7;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mr;
    logic        mill;
    int          mlat;
    int          ov_seen;

    reset = 1'b1; in_valid = 1'b0;
    ALUOp = '0; funct7 = '0; funct3 = '0;
    operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    reset = 1'b0;

    vq.push_back('{2'd2, 7'h20, 3'd5, 32'h80000000, 32'd4,
                   32'hF8000000, 1'b0, 1, "sra"});
    vq.push_back('{2'd2, 7'h00, 3'd5, 32'h80000000, 32'd4,
                   32'h08000000, 1'b0, 1, "srl"});
    vq.push_back('{2'd3, 7'h00, 3'd3, 32'd1, 32'hFFFFFFFF,
                   32'd1, 1'b0, 1, "sltiu"});
    vq.push_back('{2'd3, 7'h00, 3'd2, 32'd1, 32'hFFFFFFFF,
                   32'd0, 1'b0, 1, "slti"});
    vq.push_back('{2'd2, 7'h01, 3'd1, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'h0, 1'b0, 33, "mulh"});
    vq.push_back('{2'd2, 7'h01, 3'd3, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33,
                   "mulhu"});
    vq.push_back('{2'd2, 7'h01, 3'd4, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFD, 1'b0, 33, "div"});
    vq.push_back('{2'd2, 7'h01, 3'd6, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 1'b0, 33, "rem"});
    vq.push_back('{2'd2, 7'h01, 3'd5, 32'h1234, 32'd0,
                   32'hFFFFFFFF, 1'b0, 1, "divu_z"});
    vq.push_back('{2'd2, 7'h01, 3'd4, 32'h80000000,
                   32'hFFFFFFFF, 32'h80000000, 1'b0, 1,
                   "div_ovf"});
    vq.push_back('{2'd2, 7'h01, 3'd6, 32'h80000000,
                   32'hFFFFFFFF, 32'h0, 1'b0, 1, "rem_ovf"});
    vq.push_back('{2'd2, 7'h01, 3'd7, 32'hABCD, 32'd0,
                   32'hABCD, 1'b0, 1, "remu_z"});
    vq.push_back('{2'd2, 7'h20, 3'd7, 32'd5, 32'd3,
                   32'h0, 1'b1, 1, "ill_f7alt"});
    vq.push_back('{2'd2, 7'h11, 3'd0, 32'd5, 32'd3,
                   32'h0, 1'b1, 1, "ill_f7"});
    vq.push_back('{2'd0, 7'h7F, 3'd7, 32'd5, 32'd7,
                   32'd12, 1'b0, 1, "ls_add"});
    vq.push_back('{2'd1, 7'h01, 3'd4, 32'd3, 32'd5,
                   32'hFFFFFFFE, 1'b0, 1, "br_sub"});
    vq.push_back('{2'd2, 7'h20, 3'd0, 32'd5, 32'd7,
                   32'hFFFFFFFE, 1'b0, 1, "r_sub"});
    vq.push_back('{2'd2, 7'h01, 3'd0, 32'hFFFFFFFD, 32'd7,
                   32'hFFFFFFEB, 1'b0, 33, "mul"});
    vq.push_back('{2'd3, 7'h20, 3'd5, 32'h80000000,
                   32'h00000404, 32'hF8000000, 1'b0, 1,
                   "srai"});
    vq.push_back('{2'd3, 7'h20, 3'd0, 32'd5, 32'd7,
                   32'd12, 1'b0, 1, "addi"});

    foreach (vq[i])
      run_op(vq[i].op, vq[i].f7, vq[i].f3, vq[i].a,
             vq[i].b, vq[i].r, vq[i].ill, vq[i].lat,
             vq[i].nm);

    for (int i = 0; i < 80; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 4))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2, 3: rf7 = 7'h01;
        default: rf7 = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      ra  = pick();
      rb  = pick();
      model(rop, rf7, rf3, ra, rb, mr, mill, mlat);
      run_op(rop, rf7, rf3, ra, rb, mr, mill, mlat,
             $sformatf("rnd%0d", i));
    end

    run_op(2'd0, 7'h0, 3'd0, 32'd1, 32'd1, 32'd2,
           1'b0, 1, "pre_rst");

    @(negedge clk);
    ALUOp = 2'd2; funct7 = 7'h01; funct3 = 3'd5;
    operand_a = 32'd1000; operand_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_res", result, 32'h0);
    chk("mid_rst_zero", 32'(zero), 32'd1);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("mid_rst_noov", 32'(ov_seen), 32'd0);
    run_op(2'd0, 7'h0, 3'd0, 32'd2, 32'd3, 32'd5,
           1'b0, 1, "post_rst_add");

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
